// File: rtl/rca_seq_ctrl_pkg.sv
// Shared types and defaults for the word-serial ripple-carry add/subtract sequencer.
package rca_seq_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_N     = 8;
    localparam int DEF_WORDS = 4;

    // Word index width: clog2(words) with a one-bit floor.
    function automatic int idx_width(input int words);
        int w;
        w = $clog2(words);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder; purely combinational, one carry chain of length n.
module rca_nbit #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    // Bitwise full-adder chain, carry rippled through a block-local variable.
    always_comb begin
        logic carry_v;
        carry_v = cin;
        sum     = {n{1'b0}};
        for (int i = 0; i < n; i++) begin
            sum[i]  = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        cout = carry_v;
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide add/subtract sequenced one N-bit word per clock through a single ripple adder,
// least-significant word first, with the inter-word carry held in a register.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               overflow
);

    localparam int            W        = N * WORDS;
    localparam int            IW       = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t        state_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          sub_r;
    logic [IW-1:0] idx_r;
    logic          carry_r;

    logic [N-1:0]  a_word_s;
    logic [N-1:0]  b_word_s;
    logic [N-1:0]  sum_s;
    logic          cout_s;
    logic          ovf_s;

    // Select the current word; B is inverted for subtract (carry-in supplies the +1).
    always_comb begin
        a_word_s = a_r[idx_r*N +: N];
        b_word_s = b_r[idx_r*N +: N] ^ {N{sub_r}};
        ovf_s    = (a_r[W-1] == (b_r[W-1] ^ sub_r)) && (sum_s[N-1] != a_r[W-1]);
    end

    rca_nbit #(
        .n(N)
    ) u_add (
        .a   (a_word_s),
        .b   (b_word_s),
        .cin (carry_r),
        .sum (sum_s),
        .cout(cout_s)
    );

    // Sequencer FSM with operand latches and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            sub_r    <= 1'b0;
            idx_r    <= {IW{1'b0}};
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {W{1'b0}};
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub;
                        idx_r   <= {IW{1'b0}};
                        carry_r <= sub;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    result[idx_r*N +: N] <= sum_s;
                    carry_r              <= cout_s;
                    if (idx_r == LAST_IDX) begin
                        cout     <= cout_s;
                        overflow <= ovf_s;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        idx_r    <= {IW{1'b0}};
                        state_r  <= IDLE;
                    end else begin
                        idx_r    <= idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    idx_r   <= {IW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench: directed corner cases plus random ops against an integer-arithmetic model.
module tb_rca_seq_ctrl;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks;
    int failures;

    rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned W-bit arithmetic for result/cout, signed 64-bit range test for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic c, output logic v);
        longint sa;
        longint sb;
        longint sr;
        longint ua;
        longint ub;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        if (ms) begin
            r  = ma - mb;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ma + mb;
            c  = ((ua + ub) >= 64'sd4294967296);
            sr = sa + sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // One operation: start driven at negedge, outputs sampled 1ns after each rising edge.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         input bit repulse);
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        int           busy_cnt;
        int           done_at;
        model(oa, ob, os, er, ec, ev);
        @(negedge clk);
        start = 1'b1;
        a     = oa;
        b     = ob;
        sub   = os;
        busy_cnt = 0;
        done_at  = -1;
        for (int cyc = 0; cyc < 12 && done_at < 0; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (cyc == 0) check_eq("done_cleared_at_start", {63'd0, done}, 64'd0);
            if (busy) busy_cnt++;
            if (done) done_at = cyc;
            if (repulse && cyc == 1) begin
                start = 1'b1;
                a     = ~oa;
                b     = oa ^ ob;
                sub   = ~os;
            end
        end
        start = 1'b0;
        if (done_at < 0) begin
            check_eq("done_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("latency", 64'(done_at), 64'(WORDS));
            check_eq("busy_cycles", 64'(busy_cnt), 64'(WORDS));
            check_eq("busy_low_at_done", {63'd0, busy}, 64'd0);
            check_eq("result", {32'd0, result}, {32'd0, er});
            check_eq("cout", {63'd0, cout}, {63'd0, ec});
            check_eq("overflow", {63'd0, overflow}, {63'd0, ev});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_result", {32'd0, result}, 64'd0);
        check_eq("rst_flags", {62'd0, cout, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases, issued back to back (each start lands in the previous done cycle).
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        check_eq("dir_carry_word", {32'd0, result}, 64'h100);
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        check_eq("dir_wrap", {31'd0, cout, result}, 64'h1_0000_0000);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        check_eq("dir_pos_ovf", {62'd0, cout, overflow}, 64'd1);
        do_op(32'h00000000, 32'h00000001, 1'b1, 1'b0);
        check_eq("dir_borrow", {31'd0, cout, result}, 64'h0_FFFF_FFFF);
        do_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        check_eq("dir_neg_ovf", {30'd0, cout, overflow, result}, 64'h3_7FFF_FFFF);

        // Restart while busy must be ignored.
        do_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);
        check_eq("repulse_result", {32'd0, result}, 64'h2143_6587);

        // Reset mid-run aborts everything with no later done.
        @(negedge clk);
        start = 1'b1;
        a     = 32'hDEADBEEF;
        b     = 32'h01010101;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        check_eq("abort_result", {32'd0, result}, 64'd0);
        check_eq("abort_flags", {62'd0, cout, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) seen++;
            end
            check_eq("abort_no_done", 64'(seen), 64'd0);
        end

        // Random operations, back to back.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 16 == 0) rb = ra;
            if (i % 16 == 1) ra = 32'h80000000;
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
